pwm_spi_host: RTL and testbench

SPI master that sits directly upstream of the 2-channel SPI PWM driver and turns a parallel valid/ready command interface into the driver's two-byte SPI frames. It issues level writes and level reads, returns read data (and, optionally, write echo checks) on a one-cycle response strobe, and guarantees the SCLK/CS timing the driver needs for its clk-domain edge detection. The host and the driver can share one system clock.

---
 rtl/pwm_spi_host.sv | 196 +++++++++++++++++++
 tb/tb_pwm_spi_host.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_spi_host.sv
// SPI mode-0 host that turns valid/ready level commands into two-byte frames for the 2-channel PWM driver.
// Optional write echo readback (24-bit write frames) is enabled by defining PWM_SPI_HOST_READBACK_EN.
module pwm_spi_host #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    TAIL = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state_r, state_s;
  logic [7:0]  div_r, div_s;
  logic [4:0]  bit_r, bit_s;
  logic [23:0] tx_r, tx_s;
  logic [7:0]  rx_r, rx_s;
  logic        wr_r, wr_s;
  logic [7:0]  data_r, data_s;
  logic        sclk_r, sclk_s;
  logic        cs_r, cs_s;
  logic        mosi_r, mosi_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic [7:0]  rsp_data_r, rsp_data_s;
  logic        rsp_err_r, rsp_err_s;

  logic [4:0]  last_bit_s;
  logic        rx_en_s;
  logic [7:0]  rsp_dval_s;
  logic        rsp_eval_s;

`ifdef PWM_SPI_HOST_READBACK_EN
  // Writes append a third byte whose miso bits carry the driver's echo of the level.
  assign last_bit_s = wr_r ? 5'd23 : 5'd15;
  assign rx_en_s    = 1'b1;
  assign rsp_dval_s = rx_r;
  assign rsp_eval_s = wr_r && (rx_r != data_r);
`else
  assign last_bit_s = 5'd15;
  assign rx_en_s    = !wr_r;
  assign rsp_dval_s = wr_r ? data_r : rx_r;
  assign rsp_eval_s = 1'b0;
`endif

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    bit_s       = bit_r;
    tx_s        = tx_r;
    rx_s        = rx_r;
    wr_s        = wr_r;
    data_s      = data_r;
    sclk_s      = sclk_r;
    cs_s        = cs_r;
    mosi_s      = mosi_r;
    rsp_valid_s = 1'b0;
    rsp_data_s  = rsp_data_r;
    rsp_err_s   = rsp_err_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          state_s = LOW;
          div_s   = DIV_LAST;
          bit_s   = 5'd0;
          tx_s    = {cmd_write, 6'b000000, cmd_addr, (cmd_write ? cmd_data : 8'h00), 8'h00};
          wr_s    = cmd_write;
          data_s  = cmd_data;
          cs_s    = 1'b0;
          sclk_s  = 1'b0;
          mosi_s  = cmd_write;
        end else begin
          state_s = IDLE;
        end
      end
      LOW: begin
        if (div_r == 8'd0) begin
          state_s = HIGH;
          div_s   = DIV_LAST;
          sclk_s  = 1'b1;
        end else begin
          div_s = div_r - 8'd1;
        end
      end
      HIGH: begin
        if (div_r == 8'd0) begin
          sclk_s = 1'b0;
          div_s  = DIV_LAST;
          // miso is captured on the SCLK falling transition, LSB first
          if (rx_en_s) begin
            rx_s = {miso, rx_r[7:1]};
          end else begin
            rx_s = rx_r;
          end
          if (bit_r == last_bit_s) begin
            state_s = TAIL;
          end else begin
            state_s = LOW;
            bit_s   = bit_r + 5'd1;
            tx_s    = {tx_r[22:0], tx_r[23]};
            mosi_s  = tx_r[22];
          end
        end else begin
          div_s = div_r - 8'd1;
        end
      end
      TAIL: begin
        if (div_r == 8'd0) begin
          state_s     = GAP;
          div_s       = GAP_LAST;
          cs_s        = 1'b1;
          rsp_valid_s = 1'b1;
          rsp_data_s  = rsp_dval_s;
          rsp_err_s   = rsp_eval_s;
        end else begin
          div_s = div_r - 8'd1;
        end
      end
      GAP: begin
        if (div_r == 8'd0) begin
          state_s = IDLE;
        end else begin
          div_s = div_r - 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cs_s    = 1'b1;
        sclk_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      div_r       <= 8'd0;
      bit_r       <= 5'd0;
      tx_r        <= 24'h000000;
      rx_r        <= 8'h00;
      wr_r        <= 1'b0;
      data_r      <= 8'h00;
      sclk_r      <= 1'b0;
      cs_r        <= 1'b1;
      mosi_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      bit_r       <= bit_s;
      tx_r        <= tx_s;
      rx_r        <= rx_s;
      wr_r        <= wr_s;
      data_r      <= data_s;
      sclk_r      <= sclk_s;
      cs_r        <= cs_s;
      mosi_r      <= mosi_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  assign cmd_ready = (state_r == IDLE);
  assign sclk      = sclk_r;
  assign cs        = cs_r;
  assign mosi      = mosi_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_pwm_spi_host.sv
// Scoreboard bench for pwm_spi_host: dut 0 uses CLK_DIV=4/CS_GAP=4, dut 1 uses CLK_DIV=2/CS_GAP=1.
// Each dut talks to a behavioural model of the 2-channel PWM driver holding two level registers.
module tb_pwm_spi_host;
  localparam int NI = 2;
`ifdef PWM_SPI_HOST_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]      reset_n, cmd_valid, cmd_write, cmd_addr, ovr_en;
  logic [NI-1:0][7:0] cmd_data;
  logic [NI-1:0]      cmd_ready, rsp_valid, rsp_err, sclk, cs, mosi, at_bit5;
  logic [NI-1:0][7:0] rsp_data;
  logic [7:0]         ovr_val;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int n_exp [NI] = '{0, 0};

  typedef struct {
    int         inst;
    int         tcyc;
    int         nbits;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, inst, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [23:0] v, input int sh);
    logic [23:0] t;
    t = v >> sh;
    return t[7:0];
  endfunction

  // miso bit the driver presents for frame bit k (read level in byte 2, echo in byte 3)
  function automatic logic drv_bit(input logic [23:0] sr, input int k, input logic [7:0] l0,
                                   input logic [7:0] l1, input logic ovr, input logic [7:0] ov);
    logic [7:0] cmd, src;
    if (k >= 8 && k < 16) begin
      cmd = byte_at(sr, k - 8);
      src = cmd[0] ? l1 : l0;
      return !cmd[7] && src[3'(k - 8)];
    end else if (k >= 16 && k < 24) begin
      cmd = byte_at(sr, k - 8);
      src = ovr ? ov : byte_at(sr, k - 16);
      return cmd[7] && src[3'(k - 16)];
    end
    return 1'b0;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int DIV  = (g == 0) ? 4 : 2;
    localparam int GAPC = (g == 0) ? 4 : 1;
    logic        miso_s = 1'b0;
    logic        sclk_q = 1'b0;
    logic        cs_q = 1'b1;
    logic [23:0] mo = 24'h0;
    logic [7:0]  lvl0 = 8'h00;
    logic [7:0]  lvl1 = 8'h00;
    int          bitn = 0;
    int          rsp_cnt = 0;
    int          hi_cnt = 0;
    bit          seen_frame = 1'b0;

    pwm_spi_host #(.CLK_DIV(DIV), .CS_GAP(GAPC)) dut (
      .clk(clk), .reset_n(reset_n[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
      .cmd_addr(cmd_addr[g]), .cmd_data(cmd_data[g]),
      .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]), .rsp_err(rsp_err[g]),
      .sclk(sclk[g]), .cs(cs[g]), .mosi(mosi[g]), .miso(miso_s)
    );

    assign at_bit5[g] = (bitn == 5);

    // driver model: clk-domain SCLK edge detect, commit levels when cs rises after a whole write
    always @(posedge clk) begin
      sclk_q <= sclk[g];
      if (cs[g]) begin
        if (bitn == 16 && mo[15]) begin
          if (mo[8]) lvl1 <= mo[7:0];
          else lvl0 <= mo[7:0];
        end else if (bitn == 24 && mo[23]) begin
          if (mo[16]) lvl1 <= mo[15:8];
          else lvl0 <= mo[15:8];
        end
        bitn   <= 0;
        miso_s <= 1'b0;
      end else if (sclk[g] && !sclk_q) begin
        mo     <= {mo[22:0], mosi[g]};
        bitn   <= bitn + 1;
        miso_s <= drv_bit(mo, bitn, lvl0, lvl1, ovr_en[g], ovr_val);
      end
    end

    // response monitor: pop this dut's oldest expectation and compare
    always @(negedge clk) begin
      int idx;
      exp_t e;
      if (rsp_valid[g]) begin
        rsp_cnt++;
        idx = -1;
        for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].inst == g) idx = k;
        check("rsp_expected", g, (idx >= 0), 1);
        if (idx >= 0) begin
          e = sb[idx];
          sb.delete(idx);
          check("rsp_data", g, rsp_data[g], e.data);
          check("rsp_err", g, rsp_err[g], e.err);
          check("rsp_cycle", g, cyc, e.tcyc);
          check("rsp_cs_high", g, cs[g], 1);
          check("frame_bits", g, bitn, e.nbits);
          check("mosi_byte0", g, byte_at(mo, e.nbits - 8), e.b0);
          check("mosi_byte1", g, byte_at(mo, e.nbits - 16), e.b1);
          if (e.nbits == 24) check("mosi_byte2", g, byte_at(mo, 0), 0);
        end
      end
    end

    // cs high-time between frames and sclk idle level at frame start
    always @(negedge clk) begin
      if (cs[g]) begin
        hi_cnt++;
      end else begin
        if (cs_q && seen_frame) check("cs_gap", g, (hi_cnt >= GAPC), 1);
        if (cs_q) check("sclk_at_cs_fall", g, sclk[g], 0);
        seen_frame = 1'b1;
        hi_cnt = 0;
      end
      cs_q = cs[g];
    end
  end

  task automatic send(input int i, input logic wr, input logic a, input logic [7:0] d,
                      input logic [7:0] exp_data, input logic exp_err, input bit push, input bit hold);
    exp_t e;
    int cnt = 0;
    int nb;
    cmd_valid[i] = 1'b1;
    cmd_write[i] = wr;
    cmd_addr[i]  = a;
    cmd_data[i]  = d;
    while (!cmd_ready[i] && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("accept", i, cmd_ready[i], 1);
    @(posedge clk);
    #1;
    nb = (wr && RB) ? 24 : 16;
    e.inst  = i;
    e.tcyc  = cyc + (2 * nb + 1) * ((i == 0) ? 4 : 2);
    e.nbits = nb;
    e.b0    = {wr, 6'b000000, a};
    e.b1    = wr ? d : 8'h00;
    e.data  = exp_data;
    e.err   = exp_err;
    if (push) begin
      sb.push_back(e);
      n_exp[i]++;
    end
    @(negedge clk);
    if (!hold) cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int cnt = 0;
    int n = 0;
    forever begin
      n = 0;
      foreach (sb[k]) if (sb[k].inst == i) n++;
      if (n == 0 || cnt >= 1000) break;
      @(negedge clk);
      cnt++;
    end
    check("rsp_timeout", i, n, 0);
  endtask

  initial begin
    logic [7:0] vals [4];
    int cnt;
    vals = '{8'h00, 8'hFF, 8'h01, 8'hFE};
    reset_n = '0;
    cmd_valid = '0;
    cmd_write = '0;
    cmd_addr = '0;
    cmd_data = '0;
    ovr_en = '0;
    ovr_val = 8'h00;
    cmd_valid[0] = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid_ignored", 0, cs[0], 1);
    cmd_valid = '0;
    reset_n = '1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_cs", i, cs[i], 1);
      check("rst_sclk", i, sclk[i], 0);
      check("rst_mosi", i, mosi[i], 0);
      check("rst_rsp_valid", i, rsp_valid[i], 0);
      check("rst_rsp_data", i, rsp_data[i], 0);
      check("rst_rsp_err", i, rsp_err[i], 0);
      check("rst_cmd_ready", i, cmd_ready[i], 1);
    end

    // dut0: writes, reads, optional echo mismatch
    send(0, 1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
    wait_idle(0);
    send(0, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);
    wait_idle(0);
    send(0, 1'b0, 1'b1, 8'hC3, 8'h5A, 1'b0, 1'b1, 1'b0);
    wait_idle(0);
    send(0, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0);
    wait_idle(0);
`ifdef PWM_SPI_HOST_READBACK_EN
    ovr_en[0] = 1'b1;
    ovr_val = 8'h32;
    send(0, 1'b1, 1'b0, 8'h33, 8'h32, 1'b1, 1'b1, 1'b0);
    wait_idle(0);
    ovr_en[0] = 1'b0;
`endif

    // dut0: reset in the middle of a write to ch1 aborts it
    send(0, 1'b1, 1'b1, 8'h77, 8'h77, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    while (!at_bit5[0] && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_reach_bit5", 0, at_bit5[0], 1);
    reset_n[0] = 1'b0;
    @(negedge clk);
    check("abort_cs", 0, cs[0], 1);
    check("abort_sclk", 0, sclk[0], 0);
    check("abort_rsp_valid", 0, rsp_valid[0], 0);
    repeat (3) @(negedge clk);
    reset_n[0] = 1'b1;
    @(negedge clk);
    check("abort_ready", 0, cmd_ready[0], 1);
    send(0, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0);
    wait_idle(0);

    // dut1: cmd_valid held across alternating writes and reads of ch0
    for (int k = 0; k < 4; k++) begin
      send(1, 1'b1, 1'b0, vals[k], vals[k], 1'b0, 1'b1, 1'b1);
      send(1, 1'b0, 1'b0, 8'h00, vals[k], 1'b0, 1'b1, (k != 3));
    end
    wait_idle(1);
    repeat (10) @(negedge clk);

    check("rsp_count", 0, gi[0].rsp_cnt, n_exp[0]);
    check("rsp_count", 1, gi[1].rsp_cnt, n_exp[1]);
    check("scoreboard_left", 0, sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
